// File: rtl/pong_score_keeper.sv
// Pong game-flow controller: turns goal/start levels into score, serve timing
// and game-over state for the ball logic and the seven-segment display.
module pong_score_keeper #(
  parameter int unsigned WIN_SCORE   = 9,
  parameter int unsigned SERVE_DELAY = 50000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       goal0,
  input  logic       goal1,
  output logic       running,
  output logic [3:0] score0,
  output logic [3:0] score1,
  output logic       serving,
  output logic       serve_dir,
  output logic       game_over,
  output logic       winner
);

  localparam int unsigned     CW     = $clog2(SERVE_DELAY) + 1;
  localparam logic [CW-1:0]   RELOAD = CW'(SERVE_DELAY - 1);
  localparam logic [3:0]      WIN    = 4'(WIN_SCORE);

  typedef enum logic [1:0] {S_IDLE, S_SERVE, S_PLAY, S_OVER} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    score0_q, score0_d, score1_q, score1_d;
  logic          running_q, running_d, serving_q, serving_d;
  logic          dir_q, dir_d, over_q, over_d, winner_q, winner_d;
  logic          start_q, goal0_q, goal1_q;
  logic          start_r, goal0_r, goal1_r;
  logic [3:0]    inc0, inc1;

  // Edge history runs in every state so a level held across a state change
  // never produces a late event.
  assign start_r = start & ~start_q;
  assign goal0_r = goal0 & ~goal0_q;
  assign goal1_r = goal1 & ~goal1_q;
  assign inc0    = score0_q + 4'd1;
  assign inc1    = score1_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    score0_d  = score0_q;
    score1_d  = score1_q;
    running_d = running_q;
    serving_d = serving_q;
    dir_d     = dir_q;
    over_d    = over_q;
    winner_d  = winner_q;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_r) begin
          state_d   = S_SERVE;
          cnt_d     = RELOAD;
          score0_d  = '0;
          score1_d  = '0;
          running_d = 1'b1;
          serving_d = 1'b1;
          dir_d     = 1'b0;
          over_d    = 1'b0;
          winner_d  = 1'b0;
        end
      end
      S_SERVE: begin
        if (cnt_q == '0) begin
          state_d   = S_PLAY;
          serving_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_PLAY: begin
        if (goal0_r && goal1_r) begin
          // Simultaneous goals are a let: replay the serve, same direction.
          state_d   = S_SERVE;
          cnt_d     = RELOAD;
          serving_d = 1'b1;
        end else if (goal0_r || goal1_r) begin
          if (goal0_r) score0_d = inc0;
          else         score1_d = inc1;
          if ((goal0_r ? inc0 : inc1) == WIN) begin
            state_d   = S_OVER;
            running_d = 1'b0;
            serving_d = 1'b0;
            over_d    = 1'b1;
            winner_d  = goal1_r;
          end else begin
            state_d   = S_SERVE;
            cnt_d     = RELOAD;
            serving_d = 1'b1;
            dir_d     = goal0_r;  // serve toward the player who conceded
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      score0_q  <= '0;
      score1_q  <= '0;
      running_q <= 1'b0;
      serving_q <= 1'b0;
      dir_q     <= 1'b0;
      over_q    <= 1'b0;
      winner_q  <= 1'b0;
      start_q   <= 1'b0;
      goal0_q   <= 1'b0;
      goal1_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      score0_q  <= score0_d;
      score1_q  <= score1_d;
      running_q <= running_d;
      serving_q <= serving_d;
      dir_q     <= dir_d;
      over_q    <= over_d;
      winner_q  <= winner_d;
      start_q   <= start;
      goal0_q   <= goal0;
      goal1_q   <= goal1;
    end
  end

  assign running   = running_q;
  assign score0    = score0_q;
  assign score1    = score1_q;
  assign serving   = serving_q;
  assign serve_dir = dir_q;
  assign game_over = over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_pong_score_keeper.sv
// Directed scenarios plus randomized play checked against a game-level model.
module tb_pong_score_keeper;
  localparam int WIN = 9;
  localparam int DLY = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0, goal0 = 1'b0, goal1 = 1'b0;
  logic       running, serving, serve_dir, game_over, winner;
  logic [3:0] score0, score1;

  int total = 0;
  int bad   = 0;

  pong_score_keeper #(.WIN_SCORE(WIN), .SERVE_DELAY(DLY)) dut (
    .clock(clock), .reset(reset), .start(start), .goal0(goal0), .goal1(goal1),
    .running(running), .score0(score0), .score1(score1), .serving(serving),
    .serve_dir(serve_dir), .game_over(game_over), .winner(winner)
  );

  always #5 clock = ~clock;

  // Game-level model: phase 0=idle 1=serve 2=play 3=over; m_left counts
  // serve cycles still to spend in the pause.
  int m_phase = 0, m_left = 0, m_s0 = 0, m_s1 = 0;
  bit m_dir = 0, m_win = 0, m_ps = 0, m_p0 = 0, m_p1 = 0;
  wire m_se = start & ~m_ps;
  wire m_e0 = goal0 & ~m_p0;
  wire m_e1 = goal1 & ~m_p1;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_phase <= 0; m_left <= 0; m_s0 <= 0; m_s1 <= 0;
      m_dir <= 0; m_win <= 0; m_ps <= 0; m_p0 <= 0; m_p1 <= 0;
    end else begin
      m_ps <= start; m_p0 <= goal0; m_p1 <= goal1;
      case (m_phase)
        0, 3: if (m_se) begin
          m_phase <= 1; m_left <= DLY; m_s0 <= 0; m_s1 <= 0; m_dir <= 0; m_win <= 0;
        end
        1: begin
          m_left <= m_left - 1;
          if (m_left == 1) m_phase <= 2;
        end
        default: begin
          if (m_e0 && m_e1) begin
            m_phase <= 1; m_left <= DLY;
          end else if (m_e0) begin
            m_s0 <= m_s0 + 1;
            if (m_s0 + 1 == WIN) begin m_phase <= 3; m_win <= 0; end
            else begin m_phase <= 1; m_left <= DLY; m_dir <= 1; end
          end else if (m_e1) begin
            m_s1 <= m_s1 + 1;
            if (m_s1 + 1 == WIN) begin m_phase <= 3; m_win <= 1; end
            else begin m_phase <= 1; m_left <= DLY; m_dir <= 0; end
          end
        end
      endcase
    end
  end

  task automatic wait_serve_end();
    int n = 0;
    while (serving && n < 20) begin @(negedge clock); n++; end
    total++;
    if (serving !== 1'b0) begin
      bad++; $display("FAIL serve_timeout serving=%0b want 0", serving);
    end
  endtask

  task automatic score_goal(input int p);
    if (p == 0) goal0 = 1'b1; else goal1 = 1'b1;
    @(negedge clock);
    goal0 = 1'b0; goal1 = 1'b0;
    if (!game_over) wait_serve_end();
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 0; goal0 = 0; goal1 = 0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (10) @(negedge clock);
    total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running got=%0b want=0", running); end
    total++; if ({score0, score1} !== 8'h00) begin bad++; $display("FAIL reset_scores got=%h want=00", {score0, score1}); end
    total++; if (serving !== 1'b0) begin bad++; $display("FAIL reset_serving got=%0b want=0", serving); end
    total++; if ({game_over, winner, serve_dir} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {game_over, winner, serve_dir}); end
  endtask

  task automatic test_start_serve();
    int cnt;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    total++; if ({running, serving} !== 2'b11) begin bad++; $display("FAIL start_flags got=%b want=11", {running, serving}); end
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (serving) cnt++; else break;
    end
    total++; if (cnt != DLY) begin bad++; $display("FAIL serve_len got=%0d want=%0d", cnt, DLY); end
    total++; if ({running, serving} !== 2'b10) begin bad++; $display("FAIL play_flags got=%b want=10", {running, serving}); end
  endtask

  task automatic test_goal_held();
    int cnt = 0;
    goal0 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (serving) cnt++;
      if (i == 0) begin
        total++; if (serve_dir !== 1'b1) begin bad++; $display("FAIL held_dir got=%0b want=1", serve_dir); end
      end
      if (i == 5) goal0 = 1'b0;
    end
    total++; if ({score0, score1} !== 8'h10) begin bad++; $display("FAIL held_score got=%h want=10", {score0, score1}); end
    total++; if (cnt != DLY) begin bad++; $display("FAIL held_serve_len got=%0d want=%0d", cnt, DLY); end
  endtask

  task automatic test_let();
    goal0 = 1'b1; goal1 = 1'b1;
    @(negedge clock);
    goal0 = 1'b0; goal1 = 1'b0;
    total++; if ({score0, score1} !== 8'h10) begin bad++; $display("FAIL let_score got=%h want=10", {score0, score1}); end
    total++; if ({serving, serve_dir} !== 2'b11) begin bad++; $display("FAIL let_serve got=%b want=11", {serving, serve_dir}); end
    wait_serve_end();
  endtask

  task automatic test_win();
    for (int i = 0; i < 7; i++) score_goal(1);
    for (int i = 0; i < 8; i++) score_goal(0);
    total++; if ({score0, score1} !== 8'h97) begin bad++; $display("FAIL win_score got=%h want=97", {score0, score1}); end
    total++; if ({running, serving, game_over, winner} !== 4'b0010) begin bad++; $display("FAIL win_flags got=%b want=0010", {running, serving, game_over, winner}); end
    repeat (2) begin score_goal(0); score_goal(1); @(negedge clock); end
    total++; if ({score0, score1, game_over} !== 9'h12f) begin bad++; $display("FAIL over_frozen got=%h want=12f", {score0, score1, game_over}); end
  endtask

  task automatic test_restart();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    total++; if ({score0, score1} !== 8'h00) begin bad++; $display("FAIL restart_score got=%h want=00", {score0, score1}); end
    total++; if ({running, serving, serve_dir, game_over, winner} !== 5'b11000) begin bad++; $display("FAIL restart_flags got=%b want=11000", {running, serving, serve_dir, game_over, winner}); end
    wait_serve_end();
  endtask

  task automatic test_reset_mid_serve();
    for (int i = 0; i < 5; i++) score_goal(1);
    for (int i = 0; i < 2; i++) score_goal(0);
    goal0 = 1'b1;
    @(negedge clock);
    goal0 = 1'b0;
    total++; if ({score0, score1, serving} !== 9'h06b) begin bad++; $display("FAIL mid_pre got=%h want=06b", {score0, score1, serving}); end
    #2 reset = 1'b0;
    #1;
    total++; if ({running, score0, score1, serving, serve_dir, game_over, winner} !== 13'h0) begin
      bad++; $display("FAIL mid_reset got=%h want=0", {running, score0, score1, serving, serve_dir, game_over, winner});
    end
    @(negedge clock); reset = 1'b1;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    total++; if ({running, score0, score1} !== 9'h100) begin bad++; $display("FAIL mid_restart got=%h want=100", {running, score0, score1}); end
  endtask

  task automatic test_random();
    logic [12:0] exp_v, got_v;
    int errs = 0;
    reset = 1'b0; start = 0; goal0 = 0; goal1 = 0;
    @(negedge clock); reset = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      exp_v = {(m_phase == 1 || m_phase == 2), 4'(m_s0), 4'(m_s1), (m_phase == 1), m_dir,
               (m_phase == 3), m_win};
      got_v = {running, score0, score1, serving, serve_dir, game_over, winner};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        if (errs++ < 10) $display("FAIL random cyc=%0d got=%h want=%h", i, got_v, exp_v);
      end
      reset = ($urandom_range(0, 699) != 0);
      start = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 2) == 0) goal0 = ~goal0;
      if ($urandom_range(0, 2) == 0) goal1 = ~goal1;
    end
    reset = 1'b1; start = 0; goal0 = 0; goal1 = 0;
  endtask

  initial begin
    test_reset();
    test_start_serve();
    test_goal_held();
    test_let();
    test_win();
    test_restart();
    test_reset_mid_serve();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pong_score_keeper.md
Name: pong_score_keeper

Overview:
- Game-flow controller for Pong. Consumes goal events from the ball/collision logic and the player start button.
- Produces the running flag and per-player scores consumed directly by SevenSegManager (running, score0, score1).
- Also produces serve timing and winner outputs for the ball logic and LEDs.
- Sits between ball physics (upstream) and the seven-segment display stage (downstream).

Parameters:
- WIN_SCORE, 9, score at which a player wins; must be 1..15.
- SERVE_DELAY, 50000000, clock cycles of the serve pause (1 s at 50 MHz); must be >= 1.

Ports:
- clock  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  start/restart request, level, synchronised upstream.
- goal0  input  1  player 0 scored; level, may stay high for several cycles.
- goal1  input  1  player 1 scored; level, may stay high for several cycles.
- running  output  1  high during SERVE and PLAY, low in IDLE and GAME_OVER.
- score0  output  4  player 0 score, 0..WIN_SCORE.
- score1  output  4  player 1 score, 0..WIN_SCORE.
- serving  output  1  high while in SERVE; ball logic holds the ball centred.
- serve_dir  output  1  direction of next serve: 0 toward player 0, 1 toward player 1.
- game_over  output  1  high in GAME_OVER only.
- winner  output  1  winning player index; valid while game_over=1.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0, all edge-detect flops=0.
  - running=0, score0=0, score1=0, serving=0, serve_dir=0, game_over=0, winner=0.
  - Asserting reset mid-game clears everything immediately; there is no partial-state retention.
- Edge detect:
  - start_r = start & ~start_q; goalN_r = goalN & ~goalN_q.
  - The _q flops update every cycle in all states.
  - A held level yields exactly one event.
  - A goal already high when PLAY is entered does not score until it falls and rises again.
- All outputs are registered. An event sampled at rising edge k is reflected on the outputs after edge k (1-cycle latency).
- IDLE:
  - Outputs as at reset.
  - On start_r: go to SERVE; score0=score1=0; counter=SERVE_DELAY-1; running=1; serving=1.
- SERVE:
  - counter decrements by 1 per cycle.
  - When counter==0: go to PLAY, serving=0.
  - Goals and start are ignored in this state.
- PLAY, on goal events:
  - goal0_r only: score0+1.
  - goal1_r only: score1+1.
  - Both in the same cycle: a let. No score change; go to SERVE, counter reloaded, serve_dir unchanged.
- PLAY, after a single-player score:
  - New score == WIN_SCORE: go to GAME_OVER; running=0; serving=0; game_over=1; winner=scorer index.
  - Otherwise: go to SERVE; counter=SERVE_DELAY-1; serving=1; serve_dir = index of the player who conceded.
- Scores never exceed WIN_SCORE and never wrap. Increments use 4-bit arithmetic bounded by the WIN_SCORE check.
- GAME_OVER:
  - Scores frozen; winner and game_over held; goals ignored.
  - On start_r: go to SERVE with scores cleared; game_over=0; winner=0; running=1; serving=1; serve_dir=0.
- running is asserted in the same cycle that serving first rises, so the display switches to scores with no "PonG" glitch.
- SERVE_DELAY=1 gives exactly one SERVE cycle.
- Counter width is clog2(SERVE_DELAY)+1.

Test Plan:
- Reset then idle 10 cycles (SERVE_DELAY=4 for all tests) -> running=0, scores 0/0, game_over=0, serving=0.
- start pulse -> next cycle running=1, serving=1. serving stays high 4 cycles, then drops; state PLAY.
- In PLAY, goal0 held high 6 cycles -> score0=1 exactly once; serving=1 for 4 cycles; serve_dir=1.
- goal0 and goal1 rising in the same cycle -> scores unchanged, SERVE re-entered, serve_dir unchanged.
- Drive player 0 to 9 goals while score1=7 -> running=0, game_over=1, winner=0, score0=9, score1=7. Further goals ignored.
- Assert reset mid-SERVE with scores 3/5 -> all outputs cleared immediately. Then start -> scores 0/0, running=1.
